vc_mem_responder: RTL



---
 rtl/vc_mem_responder_pkg.sv | 30 +++
 rtl/vc_mem_responder_subword.sv | 39 +++
 rtl/vc_mem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/vc_mem_responder_pkg.sv
// Shared message layout, type encodings and length decoding for vc_mem_responder.
package vc_mem_responder_pkg;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

  localparam int REQ_MSG_W  = 67;
  localparam int RESP_MSG_W = 35;

  // Request {type, addr[31:0], len[1:0], data[31:0]}
  localparam int REQ_TYPE_BIT = 66;
  localparam int REQ_ADDR_MSB = 65;
  localparam int REQ_ADDR_LSB = 34;
  localparam int REQ_LEN_MSB  = 33;
  localparam int REQ_LEN_LSB  = 32;
  localparam int REQ_DATA_MSB = 31;
  localparam int REQ_DATA_LSB = 0;

  // Response {type, len[1:0], data[31:0]}
  localparam int RESP_TYPE_BIT = 34;
  localparam int RESP_LEN_MSB  = 33;
  localparam int RESP_LEN_LSB  = 32;
  localparam int RESP_DATA_MSB = 31;
  localparam int RESP_DATA_LSB = 0;

  function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

endpackage

// File: rtl/vc_mem_responder_subword.sv
// Byte-lane alignment for sub-word accesses: write mask, merged write word, aligned read data.
module vc_mem_responder_subword
  import vc_mem_responder_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [3:0]  wmask,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [2:0]  nb;
  logic [31:0] shifted;

  assign nb      = len_to_nbytes(len);
  assign shifted = old_word >> {offset, 3'b000};

  // Lanes past byte 3 would belong to the next word and are dropped.
  always_comb begin
    wmask  = '0;
    merged = old_word;
    for (int l = 0; l < 4; l++) begin
      if (l >= int'(offset) && (l - int'(offset)) < int'(nb)) begin
        wmask[l]          = 1'b1;
        merged[8*l +: 8]  = wdata[8*(l - int'(offset)) +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int l = 0; l < 4; l++) begin
      if (l < int'(nb)) rdata[8*l +: 8] = shifted[8*l +: 8];
    end
  end

endmodule

// File: rtl/vc_mem_responder.sv
// Single-port val/rdy memory responder with fixed-latency in-order responses.
// Optional random request stalls via `define VC_MEM_RESPONDER_RAND_STALL_EN.
module vc_mem_responder
  import vc_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ_MSG_W-1:0]  memreq_msg,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  output logic [RESP_MSG_W-1:0] memresp_msg,
  output logic                  memresp_val,
  input  logic                  init_en,
  input  logic [31:0]           init_addr,
  input  logic [31:0]           init_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic            req_type;
  logic [31:0]     req_addr;
  logic [1:0]      req_len;
  logic [31:0]     req_data;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] init_idx;
  logic [31:0]     old_word;
  logic [3:0]      wmask;
  logic [31:0]     merged;
  logic [31:0]     rdata;
  logic            stall;
  logic            accept;

  assign req_type = memreq_msg[REQ_TYPE_BIT];
  assign req_addr = memreq_msg[REQ_ADDR_MSB:REQ_ADDR_LSB];
  assign req_len  = memreq_msg[REQ_LEN_MSB:REQ_LEN_LSB];
  assign req_data = memreq_msg[REQ_DATA_MSB:REQ_DATA_LSB];

  assign req_idx  = req_addr[IDX_W+1:2];
  assign init_idx = init_addr[IDX_W+1:2];
  assign old_word = mem[req_idx];

  vc_mem_responder_subword u_subword (
    .offset   (req_addr[1:0]),
    .len      (req_len),
    .wdata    (req_data),
    .old_word (old_word),
    .wmask    (wmask),
    .merged   (merged),
    .rdata    (rdata)
  );

`ifdef VC_MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign memreq_rdy = !reset && !init_en && !stall;
  assign accept     = memreq_val && memreq_rdy;

  // Preload and request writes are exclusive because rdy drops under init_en.
  always_ff @(posedge clk) begin
    if (init_en)
      mem[init_idx] <= init_data;
    else if (accept && req_type == TYPE_WRITE && |wmask)
      mem[req_idx] <= merged;
  end

  logic        vld_p  [LATENCY];
  logic        type_p [LATENCY];
  logic [1:0]  len_p  [LATENCY];
  logic [31:0] data_p [LATENCY];

  // ---- p0 (request capture) through p[LATENCY-1] (response drive) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    type_p[0] <= req_type;
    len_p[0]  <= req_len;
    data_p[0] <= (req_type == TYPE_WRITE) ? 32'h0 : rdata;
    for (int i = 1; i < LATENCY; i++) begin
      type_p[i] <= type_p[i-1];
      len_p[i]  <= len_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  // Data stages are not reset; the message is gated so idle cycles read as zero.
  assign memresp_val = vld_p[LATENCY-1];
  assign memresp_msg = memresp_val ?
                       {type_p[LATENCY-1], len_p[LATENCY-1], data_p[LATENCY-1]} :
                       '0;

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:IDX_W+2], init_addr[31:IDX_W+2], init_addr[1:0]};

endmodule
